// File: rtl/dmem_responder_pkg.sv
// ----------------------------------------------------------------------------
// dmem_responder_pkg
//   Shared types and defaults for the tagged data-memory responder.
//   - mem_command_t : request command presented by the dcache each cycle
//   - widths of the tag, data block and address buses
//   - default sizing of the tag table, response latency and backing store
// ----------------------------------------------------------------------------
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      MEM_NONE  = 2'h0,
      MEM_LOAD  = 2'h1,
      MEM_STORE = 2'h2
   } mem_command_t;

   localparam int MEM_TAG_W   = 4;
   localparam int MEM_BLOCK_W = 64;
   localparam int ADDR_W      = 32;

   localparam int DEF_NUM_TAGS  = 15;
   localparam int DEF_LATENCY   = 10;
   localparam int DEF_MEM_WORDS = 8192;

endpackage

// File: rtl/dmem_responder_tag_pick_lowest.sv
// ----------------------------------------------------------------------------
// tag_pick_lowest
//   Lowest-set-bit priority encoder with a found flag.
//   Ports:
//     i_req   [N-1:0]  request vector, bit 0 has highest priority
//     o_idx   [W-1:0]  index of the lowest set bit (0 when none)
//     o_valid          at least one bit of i_req is set
// ----------------------------------------------------------------------------
module tag_pick_lowest #(
   parameter int N = 15,
   parameter int W = 4
) (
   input  logic [N-1:0] i_req,
   output logic [W-1:0] o_idx,
   output logic         o_valid
);

   // Scan from the top down so the last hit written is the lowest index.
   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_idx   = W'(i);
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//   Memory end of the tagged dcache<->memory protocol. Accepts one LOAD or
//   STORE per cycle, grants a nonzero transaction tag (0 = rejected, retry),
//   and returns LOAD data LATENCY cycles later stamped with the same tag.
//
//   Handshake: a request is taken in the cycle it is presented exactly when
//   mem2proc_transaction_tag is nonzero in that same cycle; a zero tag means
//   nothing happened and the requester must present the request again. A
//   response is valid for the single cycle in which mem2proc_data_tag is
//   nonzero; there is no back-pressure on responses.
//
//   Ports:
//     clock                     system clock
//     reset                     asynchronous, active-high
//     proc2mem_command  [1:0]   NONE / LOAD / STORE
//     proc2mem_addr     [31:0]  byte address, bits [2:0] ignored
//     proc2mem_data     [63:0]  STORE data block
//     mem2proc_transaction_tag [3:0]  tag granted this cycle, 0 = not taken
//     mem2proc_data     [63:0]  registered LOAD response data
//     mem2proc_data_tag [3:0]   registered response tag, 0 = no response
// ----------------------------------------------------------------------------
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int NUM_TAGS  = DEF_NUM_TAGS,
   parameter int LATENCY   = DEF_LATENCY,
   parameter int MEM_WORDS = DEF_MEM_WORDS
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [1:0]             proc2mem_command,
   input  logic [ADDR_W-1:0]      proc2mem_addr,
   input  logic [MEM_BLOCK_W-1:0] proc2mem_data,
   output logic [MEM_TAG_W-1:0]   mem2proc_transaction_tag,
   output logic [MEM_BLOCK_W-1:0] mem2proc_data,
   output logic [MEM_TAG_W-1:0]   mem2proc_data_tag
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int CNT_W = $clog2(LATENCY);

   // The countdown is visible from the cycle after acceptance. A LOAD must be
   // selectable (count 0) in cycle t+LATENCY-1 so its registered response
   // lands in t+LATENCY. A STORE stays busy in cycles t+1..t+LATENCY.
   localparam logic [CNT_W-1:0] LOAD_INIT  = CNT_W'(LATENCY - 2);
   localparam logic [CNT_W-1:0] STORE_INIT = CNT_W'(LATENCY - 1);

   // Pending table, one entry per tag (entry k holds tag k+1).
   logic [NUM_TAGS-1:0]             r_valid;
   logic [NUM_TAGS-1:0]             r_is_load;
   logic [NUM_TAGS-1:0][CNT_W-1:0]  r_count;
   logic [MEM_BLOCK_W-1:0]          r_data [NUM_TAGS];

   logic [MEM_BLOCK_W-1:0]          r_mem [MEM_WORDS];

   logic [MEM_TAG_W-1:0]            r_resp_tag;
   logic [MEM_BLOCK_W-1:0]          r_resp_data;

   mem_command_t                    w_cmd;
   logic                            w_req;
   logic                            w_accept;
   logic [IDX_W-1:0]                w_blk;
   logic [MEM_TAG_W-1:0]            w_free_idx;
   logic                            w_free_any;
   logic [MEM_TAG_W-1:0]            w_ready_idx;
   logic                            w_ready_any;
   logic [NUM_TAGS-1:0]             w_ready_req;
   logic [NUM_TAGS-1:0]             w_retire;
   logic [NUM_TAGS-1:0]             w_alloc;
   logic                            w_unused;

   assign w_cmd    = mem_command_t'(proc2mem_command);
   assign w_req    = (w_cmd == MEM_LOAD) || (w_cmd == MEM_STORE);
   assign w_blk    = proc2mem_addr[3 +: IDX_W];
   assign w_unused = ^{proc2mem_addr[2:0], proc2mem_addr[ADDR_W-1:3+IDX_W]};

   // Free set comes from registered valid bits only, so an entry retiring in
   // this cycle cannot be handed out until the next one.
   tag_pick_lowest #(.N(NUM_TAGS), .W(MEM_TAG_W)) u_free_pick (
      .i_req   (~r_valid),
      .o_idx   (w_free_idx),
      .o_valid (w_free_any)
   );

   tag_pick_lowest #(.N(NUM_TAGS), .W(MEM_TAG_W)) u_ready_pick (
      .i_req   (w_ready_req),
      .o_idx   (w_ready_idx),
      .o_valid (w_ready_any)
   );

   assign w_accept                 = w_req && w_free_any && !reset;
   assign mem2proc_transaction_tag = w_accept ? (w_free_idx + MEM_TAG_W'(1)) : '0;
   assign mem2proc_data_tag        = r_resp_tag;
   assign mem2proc_data            = r_resp_data;

   // The entry currently on the response outputs is still valid (it frees at
   // the end of this cycle) and must not be picked a second time.
   always_comb begin
      w_ready_req = '0;
      w_retire    = '0;
      w_alloc     = '0;
      for (int k = 0; k < NUM_TAGS; k++) begin
         w_ready_req[k] = r_valid[k] && r_is_load[k] && (r_count[k] == '0) &&
                          (r_resp_tag != MEM_TAG_W'(k + 1));
         w_retire[k]    = r_valid[k] && (r_is_load[k] ?
                                         (r_resp_tag == MEM_TAG_W'(k + 1)) :
                                         (r_count[k] == '0));
         w_alloc[k]     = w_accept && (w_free_idx == MEM_TAG_W'(k));
      end
   end

   // Backing store and LOAD snapshots: not reset, so memory survives reset.
   always_ff @(posedge clock) begin
      if (w_accept && (w_cmd == MEM_STORE)) begin
         r_mem[w_blk] <= proc2mem_data;
      end
      if (w_accept && (w_cmd == MEM_LOAD)) begin
         r_data[w_free_idx] <= r_mem[w_blk];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_valid     <= '0;
         r_is_load   <= '0;
         r_count     <= '0;
         r_resp_tag  <= '0;
         r_resp_data <= '0;
      end else begin
         for (int k = 0; k < NUM_TAGS; k++) begin
            if (w_alloc[k]) begin
               r_valid[k]   <= 1'b1;
               r_is_load[k] <= (w_cmd == MEM_LOAD);
               r_count[k]   <= (w_cmd == MEM_LOAD) ? LOAD_INIT : STORE_INIT;
            end else begin
               if (w_retire[k]) begin
                  r_valid[k] <= 1'b0;
               end
               if (r_count[k] != '0) begin
                  r_count[k] <= r_count[k] - CNT_W'(1);
               end
            end
         end
         if (w_ready_any) begin
            r_resp_tag  <= w_ready_idx + MEM_TAG_W'(1);
            r_resp_data <= r_data[w_ready_idx];
         end else begin
            r_resp_tag  <= '0;
            r_resp_data <= '0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
//   Two responders share one request stream: u_dut at the default latency and
//   u_dut_slow with a latency long enough to fill the whole tag table. A
//   per-instance reference model predicts every accept tag and response.
// ----------------------------------------------------------------------------
module tb_dmem_responder;
   import dmem_responder_pkg::*;

   localparam int LAT_FAST = 10;
   localparam int LAT_SLOW = 24;
   localparam int NPOOL    = 19;

   // ---------------- clock / reset ----------------
   logic        clock;
   logic        reset;
   logic [1:0]  cmd;
   logic [31:0] addr;
   logic [63:0] wdata;
   logic [3:0]  acc_tag  [2];
   logic [3:0]  rsp_tag  [2];
   logic [63:0] rsp_data [2];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   dmem_responder #(.NUM_TAGS(15), .LATENCY(LAT_FAST), .MEM_WORDS(8192)) u_dut (
      .clock                    (clock),
      .reset                    (reset),
      .proc2mem_command         (cmd),
      .proc2mem_addr            (addr),
      .proc2mem_data            (wdata),
      .mem2proc_transaction_tag (acc_tag[0]),
      .mem2proc_data            (rsp_data[0]),
      .mem2proc_data_tag        (rsp_tag[0])
   );

   dmem_responder #(.NUM_TAGS(15), .LATENCY(LAT_SLOW), .MEM_WORDS(8192)) u_dut_slow (
      .clock                    (clock),
      .reset                    (reset),
      .proc2mem_command         (cmd),
      .proc2mem_addr            (addr),
      .proc2mem_data            (wdata),
      .mem2proc_transaction_tag (acc_tag[1]),
      .mem2proc_data            (rsp_data[1]),
      .mem2proc_data_tag        (rsp_tag[1])
   );

   // ---------------- reference model ----------------
   logic [63:0] m_mem      [2][8192];
   bit          m_busy     [2][16];
   bit          m_load     [2][16];
   bit          m_shown    [2][16];
   int          m_t        [2][16];
   logic [63:0] m_snap     [2][16];
   logic [3:0]  m_rsp_tag  [2];
   logic [63:0] m_rsp_data [2];

   logic [3:0]  obs_acc [2];
   logic [3:0]  obs_rsp [2];
   logic [63:0] obs_dat [2];

   int cyc;
   int n_checks;
   int n_errors;
   int pool [NPOOL];

   // ---------------- scoreboard check ----------------
   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic int lat_of(input int u);
      return (u == 0) ? LAT_FAST : LAT_SLOW;
   endfunction

   // Block index: byte address in 8-byte blocks, wrapping at the store depth.
   function automatic int blk(input logic [31:0] a);
      return int'((a / 32'd8) % 32'd8192);
   endfunction

   function automatic logic [3:0] model_free(input int u);
      for (int t = 1; t <= 15; t++) begin
         if (!m_busy[u][t]) return 4'(t);
      end
      return 4'd0;
   endfunction

   task automatic model_clear();
      for (int u = 0; u < 2; u++) begin
         for (int t = 0; t < 16; t++) begin
            m_busy[u][t]  = 1'b0;
            m_shown[u][t] = 1'b0;
         end
         m_rsp_tag[u]  = 4'd0;
         m_rsp_data[u] = 64'd0;
      end
   endtask

   // End-of-cycle bookkeeping for cycle cyc with accept tag e.
   task automatic model_commit(input int u, input logic [3:0] e);
      // A response shown this cycle frees its tag; stores free LATENCY cycles on.
      if (m_rsp_tag[u] != 4'd0) m_busy[u][m_rsp_tag[u]] = 1'b0;
      for (int t = 1; t <= 15; t++) begin
         if (m_busy[u][t] && !m_load[u][t] && (m_t[u][t] + lat_of(u) == cyc))
            m_busy[u][t] = 1'b0;
      end
      if (e != 4'd0) begin
         m_busy[u][e]  = 1'b1;
         m_load[u][e]  = (cmd == MEM_LOAD);
         m_t[u][e]     = cyc;
         m_shown[u][e] = 1'b0;
         if (cmd == MEM_LOAD) m_snap[u][e] = m_mem[u][blk(addr)];
         else                 m_mem[u][blk(addr)] = wdata;
      end
      // Response for next cycle: lowest tag among loads whose latency has run out.
      m_rsp_tag[u]  = 4'd0;
      m_rsp_data[u] = 64'd0;
      for (int t = 1; t <= 15; t++) begin
         if (m_rsp_tag[u] == 4'd0 && m_busy[u][t] && m_load[u][t] && !m_shown[u][t] &&
             (m_t[u][t] + lat_of(u) <= cyc + 1)) begin
            m_rsp_tag[u]  = 4'(t);
            m_rsp_data[u] = m_snap[u][t];
            m_shown[u][t] = 1'b1;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called just after a rising edge; drives one cycle, checks at the falling edge.
   task automatic step(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d);
      logic [3:0] e;
      cmd   = c;
      addr  = a;
      wdata = d;
      @(negedge clock);
      for (int u = 0; u < 2; u++) begin
         e = (c == MEM_LOAD || c == MEM_STORE) ? model_free(u) : 4'd0;
         chk($sformatf("acc_tag[%0d]", u), acc_tag[u], e);
         chk($sformatf("rsp_tag[%0d]", u), rsp_tag[u], m_rsp_tag[u]);
         chk($sformatf("rsp_data[%0d]", u), rsp_data[u], m_rsp_data[u]);
         obs_acc[u] = acc_tag[u];
         obs_rsp[u] = rsp_tag[u];
         obs_dat[u] = rsp_data[u];
         model_commit(u, e);
      end
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(MEM_NONE, 32'd0, 64'd0);
   endtask

   // Asserts reset mid-cycle while a LOAD is presented; outputs must clear at once.
   task automatic mid_reset();
      cmd  = MEM_LOAD;
      addr = 32'h100;
      #2 reset = 1'b1;
      #1;
      for (int u = 0; u < 2; u++) begin
         chk($sformatf("rst_acc[%0d]", u), acc_tag[u], 64'd0);
         chk($sformatf("rst_rsp_tag[%0d]", u), rsp_tag[u], 64'd0);
         chk($sformatf("rst_rsp_data[%0d]", u), rsp_data[u], 64'd0);
      end
      model_clear();
      @(negedge clock);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      cmd   = MEM_NONE;
      @(posedge clock);
      #1;
      cyc += 3;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [63:0] d100;
      logic [63:0] wrap_val;
      logic [12:0] b;
      int          r;
      reset    = 1'b0;
      cmd      = MEM_NONE;
      addr     = 32'd0;
      wdata    = 64'd0;
      cyc      = 0;
      n_checks = 0;
      n_errors = 0;
      model_clear();
      #1;
      mid_reset();

      // Preload a pool of blocks (spaced so neither table fills).
      pool[0] = 32'h20;
      pool[1] = 32'h40;
      pool[2] = 32'h1;
      for (int i = 3; i < NPOOL; i++) pool[i] = $urandom_range(2, 8191);
      d100 = 64'h0123_4567_89AB_CDEF;
      for (int i = 0; i < NPOOL; i++) begin
         step(MEM_STORE, 32'(pool[i]) << 3, (i == 0) ? d100 : {$urandom, $urandom});
         step(MEM_NONE, 32'd0, 64'd0);
      end
      idle(30);

      // Single LOAD on an empty table.
      step(MEM_LOAD, 32'h100, 64'd0);
      chk("t1_acc", obs_acc[0], 64'd1);
      for (int i = 1; i <= 11; i++) begin
         step(MEM_NONE, 32'd0, 64'd0);
         if (i == LAT_FAST) begin
            chk("t1_rsp_tag", obs_rsp[0], 64'd1);
            chk("t1_rsp_data", obs_dat[0], d100);
         end else begin
            chk("t1_quiet", obs_rsp[0], 64'd0);
         end
      end
      idle(30);

      // STORE then LOAD of the same block.
      step(MEM_STORE, 32'h200, 64'hDEADBEEF_CAFEF00D);
      chk("t2_st_acc", obs_acc[0], 64'd1);
      step(MEM_LOAD, 32'h200, 64'd0);
      chk("t2_ld_acc", obs_acc[0], 64'd2);
      for (int i = 2; i <= 11; i++) begin
         step(MEM_NONE, 32'd0, 64'd0);
         if (i == 11) begin
            chk("t2_rsp_tag", obs_rsp[0], 64'd2);
            chk("t2_rsp_data", obs_dat[0], 64'hDEADBEEF_CAFEF00D);
         end
      end
      idle(30);

      // Fill the slow instance's table; tag 1 reusable only the cycle after it responds.
      for (int i = 0; i <= LAT_SLOW + 1; i++) begin
         step(MEM_LOAD, 32'h100, 64'd0);
         if (i < 15)             chk("t3_acc", obs_acc[1], 64'(i + 1));
         else if (i <= LAT_SLOW) chk("t3_full", obs_acc[1], 64'd0);
         else                    chk("t3_reuse", obs_acc[1], 64'd1);
         if (i == LAT_SLOW) chk("t3_rsp_tag", obs_rsp[1], 64'd1);
      end
      idle(40);

      // Reset with three LOADs in flight.
      for (int i = 0; i < 3; i++) step(MEM_LOAD, 32'h200, 64'd0);
      idle(2);
      mid_reset();
      step(MEM_LOAD, 32'h200, 64'd0);
      chk("t5_acc_fast", obs_acc[0], 64'd1);
      chk("t5_acc_slow", obs_acc[1], 64'd1);
      for (int i = 1; i <= LAT_SLOW; i++) begin
         step(MEM_NONE, 32'd0, 64'd0);
         if (i == LAT_FAST) chk("t5_mem_fast", obs_dat[0], 64'hDEADBEEF_CAFEF00D);
         if (i == LAT_SLOW) chk("t5_mem_slow", obs_dat[1], 64'hDEADBEEF_CAFEF00D);
      end
      idle(10);

      // Address wrap: upper address bits select the same block.
      wrap_val = 64'hA5A5_0001_0008_5A5A;
      step(MEM_STORE, 32'h0001_0008, wrap_val);
      step(MEM_LOAD, 32'h0000_0008, 64'd0);
      for (int i = 2; i <= 11; i++) begin
         step(MEM_NONE, 32'd0, 64'd0);
         if (i == 11) begin
            chk("t6_rsp_tag", obs_rsp[0], 64'd2);
            chk("t6_rsp_data", obs_dat[0], wrap_val);
         end
      end
      idle(30);

      // Random traffic over the preloaded pool with random upper address bits.
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 3);
         b = 13'(pool[$urandom_range(0, NPOOL - 1)]);
         if (r <= 1)      step(MEM_LOAD, {16'($urandom), b, 3'($urandom)}, 64'd0);
         else if (r == 2) step(MEM_STORE, {16'($urandom), b, 3'($urandom)}, {$urandom, $urandom});
         else             step(MEM_NONE, 32'd0, 64'd0);
      end
      idle(40);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
